fetch_pc_unit: RTL and testbench

- Instruction-fetch front end of the CPU.
- Owns the PC register and drives the shared 32-bit adder: pc_cur goes to the adder's first input, the second input is tied to 4 outside this block, and the adder result returns as pc_plus4.
- Issues instruction-memory requests over a req/ack handshake and delivers {pc, inst} to decode over valid/ready, through a 2-entry output buffer.
- Handles branch/jump redirects, including a redirect that arrives while a memory request is still outstanding.

---
 rtl/fetch_pc_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory
// requests over req/ack and hands {pc, inst} to decode through a
// 2-entry buffer (output entry + skid entry). Redirects flush the buffer
// and may arrive while a memory request is still in flight.
module fetch_pc_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(32'h0000_3000)
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [DATA_WIDTH-1:0] pc_cur,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  input  logic                  id_ready,
  output logic                  misalign
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic                    req_q, req_d;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0]   out_inst_q, out_inst_d;
  logic                    skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0]   skid_inst_q, skid_inst_d;
  logic                    misalign_q, misalign_d;
  logic                    halt_pend_q, halt_pend_d;

  logic                    fire_c;
  logic                    space_c;
  logic                    redir_bad_c;
  logic                    outstanding_c;

  // Handshake and redirect qualifiers shared by the next-state logic
  always_comb begin
    fire_c        = out_vld_q & id_ready;
    space_c       = ~out_vld_q | id_ready;
    redir_bad_c   = redirect_valid & (redirect_pc[1:0] != 2'b00);
    outstanding_c = ((state_q == S_FETCH) || (state_q == S_DRAIN)) & ~imem_ack;
  end

  // Next-state, PC, request address and buffer updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    out_vld_d   = out_vld_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    skid_vld_d  = skid_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    misalign_d  = misalign_q;
    halt_pend_d = halt_pend_q;

    // A transfer to decode retires the output entry unless refilled below
    if (fire_c) begin
      out_vld_d = 1'b0;
    end

    if (redirect_valid && (state_q != S_HALT)) begin
      // Flush wins over any same-cycle transfer or ack
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      if (redir_bad_c) begin
        misalign_d = 1'b1;
        if (outstanding_c) begin
          state_d     = S_DRAIN;
          halt_pend_d = 1'b1;
        end else begin
          state_d = S_HALT;
        end
      end else begin
        pc_d = redirect_pc;
        if (outstanding_c) begin
          state_d = S_DRAIN;
        end else if (halt_pend_q) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          addr_d  = redirect_pc;
        end
      end
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
          addr_d  = pc_q;
        end
        S_FETCH: begin
          if (imem_ack) begin
            pc_d   = pc_plus4;
            addr_d = pc_plus4;
            if (space_c) begin
              out_vld_d  = 1'b1;
              out_pc_d   = pc_q;
              out_inst_d = imem_rdata;
            end else begin
              skid_vld_d  = 1'b1;
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              state_d     = S_STALL;
            end
          end
        end
        S_STALL: begin
          if (id_ready) begin
            out_vld_d  = 1'b1;
            out_pc_d   = skid_pc_q;
            out_inst_d = skid_inst_q;
            skid_vld_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            addr_d  = pc_q;
            state_d = halt_pend_q ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          out_vld_d  = 1'b0;
          skid_vld_d = 1'b0;
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      misalign_q  <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      out_vld_q   <= out_vld_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      skid_vld_q  <= skid_vld_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      misalign_q  <= misalign_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign pc_cur    = pc_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = out_vld_q;
  assign if_pc     = out_pc_q;
  assign if_inst   = out_inst_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: random memory/decode/redirect stimulus with a
// transaction-level reference model and a decoupled output scoreboard,
// plus directed scenarios for stall, drain, wrap, misalign and reset.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_cur;
  logic [31:0] pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  ent_t        sb_q[$];
  logic [31:0] exp_addr = RST_PC;
  bit          discard = 1'b0;
  bit          model_en = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  // Driver knobs
  bit          drv_en = 1'b0;
  int unsigned ack_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned redir_pct = 0;
  int unsigned ack_lat = 0;
  int unsigned wait_cnt = 0;
  bit          redir_once = 1'b0;
  logic [31:0] redir_tgt = '0;

  fetch_pc_unit dut (
    .clk(clk), .rstn(rstn), .pc_cur(pc_cur), .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .id_ready(id_ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Shared adder and instruction memory contents
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign pc_plus4   = pc_cur + 32'd4;
  assign imem_rdata = inst_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
    return 32'h0000_4000 + 32'($urandom_range(1023)) * 32'd4;
  endfunction

  // Memory / decode / redirect driver, one step after each rising edge
  always @(posedge clk) begin
    #1;
    if (!rstn || !drv_en) begin
      imem_ack       = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      wait_cnt       = 0;
    end else begin
      if (ack_lat != 0) imem_ack = imem_req && (wait_cnt >= ack_lat);
      else              imem_ack = imem_req && ($urandom_range(99) < ack_pct);
      if (imem_req) wait_cnt = imem_ack ? 0 : wait_cnt + 1;
      id_ready = ($urandom_range(99) < rdy_pct);
      if (redir_once) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        redir_once     = 1'b0;
      end else if ($urandom_range(99) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end else begin
        redirect_valid = 1'b0;
      end
    end
  end

  // Reference model: expected fetch stream, pushed when an ack is accepted
  always @(negedge clk) begin
    if (model_en) begin
      check("valid_vs_pending", 32'(if_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() >= 2) check("req_when_full", 32'(imem_req), 32'd0);
      if (prev_wait) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, prev_addr);
      end
      if (redirect_valid) begin
        sb_q.delete();
        discard  = imem_req && !imem_ack;
        exp_addr = redirect_pc;
      end else if (imem_req && imem_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          check("req_addr", imem_addr, exp_addr);
          sb_q.push_back('{pc: exp_addr, inst: inst_of(exp_addr)});
          exp_addr = exp_addr + 32'd4;
        end
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Monitor: pops and compares every entry decode accepts
  always @(negedge clk) begin
    if (model_en) begin
      #1;
      if (!redirect_valid && if_valid && id_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got pc %h, want no transfer at %0t", if_pc, $time);
        end else begin
          ent_t e;
          e = sb_q.pop_front();
          check("out_pc", if_pc, e.pc);
          check("out_inst", if_inst, e.inst);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc_cur"}, pc_cur, RST_PC);
    check({tag, "_imem_addr"}, imem_addr, RST_PC);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_inst"}, if_inst, 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  task automatic do_reset(input bit en_model);
    model_en = 1'b0;
    drv_en   = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals("reset");
    sb_q.delete();
    discard   = 1'b0;
    exp_addr  = RST_PC;
    prev_wait = 1'b0;
    @(negedge clk);
    rstn     = 1'b1;
    drv_en   = 1'b1;
    model_en = en_model;
  endtask

  task automatic wait_req();
    int k = 0;
    @(negedge clk);
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: got req=0 after %0d cycles, want req=1", k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved_pc;
    int          k;

    // Reset release with ack tied high and decode always ready
    ack_pct = 100; rdy_pct = 100; redir_pct = 0; ack_lat = 0;
    do_reset(1'b1);
    wait_req();
    check("t1_addr0", imem_addr, 32'h0000_3000);
    check("t1_valid0", 32'(if_valid), 32'd0);
    @(negedge clk);
    check("t1_addr1", imem_addr, 32'h0000_3004);
    check("t1_ifpc0", if_pc, 32'h0000_3000);
    @(negedge clk);
    check("t1_addr2", imem_addr, 32'h0000_3008);
    check("t1_ifpc1", if_pc, 32'h0000_3004);

    // Decode stalls: second ack lands in skid, requests stop
    rdy_pct = 0;
    repeat (3) @(negedge clk);
    check("t2_stall_req", 32'(imem_req), 32'd0);
    check("t2_stall_valid", 32'(if_valid), 32'd1);
    rdy_pct = 100;
    repeat (8) @(negedge clk);

    // Redirect one cycle after req rises, ack latency 3
    do_reset(1'b1);
    ack_lat = 3;
    wait_req();
    redir_once = 1'b1;
    redir_tgt  = 32'h0000_4000;
    @(negedge clk);
    @(negedge clk);
    check("t3_drain_addr", imem_addr, 32'h0000_3000);
    check("t3_drain_req", 32'(imem_req), 32'd1);
    k = 0;
    while (!if_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t3_first_pc", if_pc, 32'h0000_4000);

    // Redirect coinciding with ack and id_ready while output is valid
    ack_lat = 0; ack_pct = 100;
    k = 0;
    @(negedge clk);
    while (!(if_valid && imem_req) && k < 20) begin
      @(negedge clk);
      k++;
    end
    redir_once = 1'b1;
    redir_tgt  = 32'h0000_5000;
    @(negedge clk);
    check("t4_pre_valid", 32'(if_valid), 32'd1);
    @(negedge clk);
    check("t4_flushed", 32'(if_valid), 32'd0);
    check("t4_addr", imem_addr, 32'h0000_5000);

    // Address wrap from the top of the address space
    redir_once = 1'b1;
    redir_tgt  = 32'hFFFF_FFFC;
    @(negedge clk);
    @(negedge clk);
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t6_addr_wrap", imem_addr, 32'h0000_0000);
    check("t6_no_misalign", 32'(misalign), 32'd0);

    // Random traffic against the reference model
    ack_pct = 60; rdy_pct = 60; redir_pct = 6;
    repeat (3000) @(negedge clk);
    redir_pct = 0; rdy_pct = 100; ack_pct = 100;
    repeat (20) @(negedge clk);

    // Misaligned redirect while a request is outstanding
    model_en = 1'b0;
    ack_lat  = 3;
    k = 0;
    @(negedge clk);
    while (!imem_ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    redir_once = 1'b1;
    redir_tgt  = 32'h0000_6002;
    @(negedge clk);
    saved_pc = pc_cur;
    @(negedge clk);
    check("t5_misalign", 32'(misalign), 32'd1);
    check("t5_flush", 32'(if_valid), 32'd0);
    check("t5_drain_req", 32'(imem_req), 32'd1);
    k = 0;
    while (imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t5_req_fell", 32'(imem_req), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("t5_halt_req", 32'(imem_req), 32'd0);
      check("t5_halt_valid", 32'(if_valid), 32'd0);
    end
    check("t5_sticky", 32'(misalign), 32'd1);
    check("t5_pc_kept", pc_cur, saved_pc);

    // Asynchronous reset in the middle of a drain
    do_reset(1'b0);
    ack_lat = 3;
    wait_req();
    redir_once = 1'b1;
    redir_tgt  = 32'h0000_6002;
    @(negedge clk);
    @(negedge clk);
    check("t5b_drain_req", 32'(imem_req), 32'd1);
    check("t5b_drain_mis", 32'(misalign), 32'd1);
    #2 rstn = 1'b0;
    #1 check_reset_vals("midrain");
    drv_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
